pipe_adder: RTL and testbench
=============================

# pipe_adder

Parametrised, pipelined add/subtract unit with valid/ready handshaking on both sides. It is the successor to the single-cycle registered adder: configurable width and pipeline depth, per-transaction add/subtract mode, and a pass-through tag for scoreboarding. It also supports backpressure and bubble collapsing. It sits between an operand producer and any result consumer in the datapath and sustains one operation per cycle when unstalled.

## Interface
- WIDTH, 32, operand width in bits; WIDTH % STAGES == 0
- STAGES, 2, pipeline depth (1..8); each stage resolves WIDTH/STAGES bits of the carry chain
- TAG_W, 4, width of user tag carried alongside each operation

- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept a beat this cycle
- a  input  WIDTH  operand A (unsigned)
- b  input  WIDTH  operand B (unsigned)
- sub  input  1  0: A+B, 1: A−B
- in_tag  input  TAG_W  user tag
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH+1  result; MSB is carry (add) or borrow (sub)
- out_tag  output  TAG_W  tag of the result beat

## Operation
- Beat accepted when in_valid && in_ready; result presented when out_valid; consumed when out_valid && out_ready.
- Add: sum = {1'b0,a} + {1'b0,b}, full WIDTH+1 bits, no truncation.
- Sub: sum = ({1'b0,a} − {1'b0,b}) mod 2^(WIDTH+1); sum[WIDTH]=1 exactly when b > a (borrow). Implemented as a + ~b + 1 with carry-out inverted into MSB.
- Stage k (0-based) adds slice [k*W/S +: W/S] with the carry registered from stage k−1. Operand upper slices and finished lower slices travel in stage registers (skew/deskew). Stage 0 captures from the input; stage STAGES−1 drives sum/out_tag/out_valid.
- Each stage holds one valid bit. Stage i loads when it is empty or its contents move to stage i+1 (last stage: out_ready). Bubbles collapse; in_ready = !v[0] || stage 0 advancing.
- Ordering strictly preserved; no beat dropped or duplicated; tag stays paired with its operands.
- When out_valid && !out_ready, sum and out_tag hold stable until accepted.

## Timing
- Reset (async assert, sync-to-clk release): all stage valids 0; out_valid=0, sum=0, out_tag=0. in_ready=1 the first cycle after reset deasserts.
- Latency: a beat accepted at edge N appears on out_valid after edge N+STAGES−1, i.e. it is consumable at edge N+STAGES (STAGES=1: result on output the cycle after acceptance).
- Throughput: 1 beat/cycle while out_ready=1.
- Capacity: STAGES beats in flight. With out_ready held low, in_ready drops once all stages full (after STAGES accepts).
- out_ready rising while full: in_ready is 1 in the same cycle (combinational through the stall chain); simultaneous accept and output in one edge allowed.
- Reset mid-operation: all in-flight beats discarded, no partial result appears after reset.
- in_ready does not depend on in_valid.

## Configuration
- PIPE_ADDER_STATS_EN defined: adds outputs res_count [15:0] and carry_count [15:0]. They increment on each consumed result and on each consumed result with sum[WIDTH]=1, respectively. Both saturate at 16'hFFFF, reset to 0, and update on the clock after the consume edge.
- Undefined: those ports and counters do not exist; all other behaviour identical.

## Test plan
- Reset then idle, WIDTH=32: out_valid=0, sum=0, in_ready=1; rst asserted asynchronously between edges clears out_valid immediately.
- Add a=32'hFFFFFFFF, b=1, tag=3, STAGES=2: result appears 2 edges later, sum=33'h1_0000_0000, out_tag=3.
- Sub a=5, b=7: sum=33'h1_FFFFFFFE (borrow=1). Sub a=7, b=5: sum=2.
- Backpressure: out_ready=0, stream 4 beats at STAGES=2. Only 2 accepted, in_ready=0, sum stable. Release out_ready: all 4 emerge in order, correct tags.
- Random streaming: 1000 beats with random valid/ready, checked against a queue scoreboard. Zero mismatches, full throughput when both sides held high.
- Reset mid-stream with 2 beats in flight: no stale results afterwards. With PIPE_ADDER_STATS_EN, 3 results (1 carry) consumed gives res_count=3, carry_count=1.

Source files
------------

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: each of STAGES stages resolves WIDTH/STAGES carry-chain bits. Latency is STAGES edges.
// Backpressure: valid/ready per stage with bubble collapse; in_ready ripples combinationally from out_ready.
// Optional PIPE_ADDER_STATS_EN adds saturating res_count/carry_count outputs.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic [TAG_W-1:0] out_tag
`ifdef PIPE_ADDER_STATS_EN
    ,
    output logic [15:0]      res_count,
    output logic [15:0]      carry_count
`endif
);

    localparam int SW  = WIDTH / STAGES;
    // Stage k keeps only the B slices still to be added, so all skewed B storage is one flat vector.
    localparam int BXW = SW * ((STAGES * (STAGES - 1)) / 2);
    localparam int BXD = (BXW > 0) ? BXW : 1;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] sub_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  x_q   [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [BXD-1:0]    bx_q;
    logic [WIDTH-1:0]  b_eff;

    assign b_eff = sub ? ~b : b;

    always_comb begin
        rdy[STAGES-1] = !v_q[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            rdy[k] = !v_q[k] || rdy[k+1];
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = {sub_q[STAGES-1] ^ c_q[STAGES-1], x_q[STAGES-1]};
    assign out_tag   = tag_q[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO   = k * SW;
        localparam int REM  = WIDTH - (k + 1) * SW;
        localparam int OFF  = SW * (k * (STAGES - 1) - (k * (k - 1)) / 2);
        localparam int OFFP = SW * ((k - 1) * (STAGES - 1) - ((k - 1) * (k - 2)) / 2);

        logic             in_v;
        logic             cin;
        logic             s_in;
        logic [SW-1:0]    op_a;
        logic [SW-1:0]    op_b;
        logic [TAG_W-1:0] t_in;
        logic [SW:0]      part;
        logic [WIDTH-1:0] x_nxt;

        // x carries finished result slices below LO and untouched A slices above.
        if (k == 0) begin : g_head
            assign in_v = in_valid;
            assign cin  = sub;
            assign s_in = sub;
            assign op_a = a[SW-1:0];
            assign op_b = b_eff[SW-1:0];
            assign t_in = in_tag;
            always_comb begin
                x_nxt         = a;
                x_nxt[SW-1:0] = part[SW-1:0];
            end
        end else begin : g_body
            assign in_v = v_q[k-1];
            assign cin  = c_q[k-1];
            assign s_in = sub_q[k-1];
            assign op_a = x_q[k-1][LO +: SW];
            assign op_b = bx_q[OFFP +: SW];
            assign t_in = tag_q[k-1];
            always_comb begin
                x_nxt           = x_q[k-1];
                x_nxt[LO +: SW] = part[SW-1:0];
            end
        end

        assign part = {1'b0, op_a} + {1'b0, op_b} + {{SW{1'b0}}, cin};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q[k]   <= 1'b0;
                c_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
                x_q[k]   <= '0;
                tag_q[k] <= '0;
            end else if (rdy[k]) begin
                v_q[k] <= in_v;
                if (in_v) begin
                    c_q[k]   <= part[SW];
                    sub_q[k] <= s_in;
                    x_q[k]   <= x_nxt;
                    tag_q[k] <= t_in;
                end
            end
        end

        if (k < STAGES - 1) begin : g_bx
            logic [REM-1:0] bx_nxt;
            if (k == 0) begin : g_src0
                assign bx_nxt = b_eff[WIDTH-1:SW];
            end else begin : g_srck
                assign bx_nxt = bx_q[OFFP + SW +: REM];
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    bx_q[OFF +: REM] <= '0;
                end else if (rdy[k] && in_v) begin
                    bx_q[OFF +: REM] <= bx_nxt;
                end
            end
        end
    end

    if (BXW == 0) begin : g_nobx
        assign bx_q = '0;
    end

`ifdef PIPE_ADDER_STATS_EN
    logic fire_q;
    logic fire_c_q;

    // Counters see the consume one clock later, off the output timing path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_q      <= 1'b0;
            fire_c_q    <= 1'b0;
            res_count   <= '0;
            carry_count <= '0;
        end else begin
            fire_q   <= out_valid && out_ready;
            fire_c_q <= out_valid && out_ready && sum[WIDTH];
            if (fire_q && res_count != 16'hFFFF) begin
                res_count <= res_count + 16'd1;
            end
            if (fire_c_q && carry_count != 16'hFFFF) begin
                carry_count <= carry_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Directed and scoreboarded checks for pipe_adder at WIDTH=32, STAGES=2, TAG_W=4.
module tb_pipe_adder;

    localparam int W  = 32;
    localparam int S  = 2;
    localparam int TW = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sub;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W:0]    sum;
    logic [TW-1:0] out_tag;
`ifdef PIPE_ADDER_STATS_EN
    logic [15:0]   res_count;
    logic [15:0]   carry_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pipe_adder #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .sub        (sub),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum),
        .out_tag    (out_tag)
`ifdef PIPE_ADDER_STATS_EN
        ,
        .res_count  (res_count),
        .carry_count(carry_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat: checks acceptance, latency, result, tag and drain.
    task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic ts, input logic [TW-1:0] tt, input logic [W:0] esum);
        int lat;
        out_ready = 1'b1;
        a = ta; b = tb_v; sub = ts; in_tag = tt; in_valid = 1'b1;
        #1;
        chk({nm, "_rdy"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({nm, "_lat"}, lat, S - 1);
        chk({nm, "_sum"}, sum, esum);
        chk({nm, "_tag"}, out_tag, tt);
        tick();
        chk({nm, "_drain"}, out_valid, 0);
    endtask

    // Random or saturated streaming against a reference queue.
    task automatic stream(input int n, input int pv, input int pr, output int stalls);
        logic [W+TW:0] exp_q[$];
        logic [W+TW:0] e;
        logic [W:0]    m;
        int sent, got, cyc;
        bit acc;
        sent = 0; got = 0; cyc = 0; stalls = 0;
        in_valid = 1'b0;
        while (got < n && cyc < 20000) begin
            if (!in_valid && sent < n && $urandom_range(99) < pv) begin
                a = $urandom; b = $urandom; sub = $urandom_range(1); in_tag = TW'($urandom);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(99) < pr);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_extra", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_beat", {out_tag, sum}, e);
                end
                got++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                m = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
                exp_q.push_back({in_tag, m});
                sent++;
            end else if (in_valid) begin
                stalls++;
            end
            tick();
            cyc++;
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("rnd_count", got, n);
        chk("rnd_left", exp_q.size(), 0);
    endtask

    logic [W-1:0]  bp_a [4];
    logic [W-1:0]  bp_b [4];
    logic          bp_s [4];
    logic [W:0]    bp_e [4];

    initial begin
        int idx, oidx, stalls, stale;

        bp_a[0] = 32'h0000_0010; bp_b[0] = 32'h0000_0020; bp_s[0] = 1'b0; bp_e[0] = 33'h0_0000_0030;
        bp_a[1] = 32'h8000_0000; bp_b[1] = 32'h8000_0000; bp_s[1] = 1'b0; bp_e[1] = 33'h1_0000_0000;
        bp_a[2] = 32'h0000_0003; bp_b[2] = 32'h0000_0009; bp_s[2] = 1'b1; bp_e[2] = 33'h1_FFFF_FFFA;
        bp_a[3] = 32'h0001_0000; bp_b[3] = 32'h0000_0001; bp_s[3] = 1'b1; bp_e[3] = 33'h0_0000_FFFF;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; in_tag = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        tick();

        run_op("add_carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'd3, 33'h1_0000_0000);
        run_op("sub_borrow", 32'd5, 32'd7, 1'b1, 4'd9, 33'h1_FFFF_FFFE);
        run_op("sub_pos", 32'd7, 32'd5, 1'b1, 4'd6, 33'h0_0000_0002);
        run_op("add_slice", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 4'd12, 33'h0_0001_0000);
        run_op("sub_equal", 32'h1234_5678, 32'h1234_5678, 1'b1, 4'd15, 33'h0_0000_0000);

        // Backpressure: only S beats fit while the consumer stalls.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            a = bp_a[idx]; b = bp_b[idx]; sub = bp_s[idx]; in_tag = TW'(idx + 1); in_valid = 1'b1;
            #1;
            if (in_ready) idx++;
            tick();
        end
        chk("bp_accepted", idx, S);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_hold_sum", sum, bp_e[0]);
        chk("bp_hold_tag", out_tag, 1);
        a = bp_a[idx]; b = bp_b[idx]; sub = bp_s[idx]; in_tag = TW'(idx + 1);
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", in_ready, 1);
        oidx = 0;
        for (int c = 0; c < 20 && oidx < 4; c++) begin
            if (out_valid) begin
                chk("bp_sum", sum, bp_e[oidx]);
                chk("bp_tag", out_tag, oidx + 1);
                oidx++;
            end
            if (in_valid && in_ready) idx++;
            tick();
            if (idx < 4) begin
                a = bp_a[idx]; b = bp_b[idx]; sub = bp_s[idx]; in_tag = TW'(idx + 1); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
        end
        chk("bp_count", oidx, 4);
        in_valid = 1'b0;
        tick();

        stream(1000, 70, 70, stalls);
        stream(50, 100, 100, stalls);
        chk("thru_stalls", stalls, 0);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            a = 32'hFFFF_FFFF; b = 32'd1; sub = 1'b0; in_tag = 4'd7; in_valid = 1'b1;
            #1;
            if (in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        chk("mid_inflight", idx, 2);
        chk("mid_pre_valid", out_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_async_clear", out_valid, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mid_in_ready", in_ready, 1);
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) stale++;
            tick();
        end
        chk("mid_stale", stale, 0);

        run_op("st_add_c", 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd1, 33'h1_0000_0000);
        run_op("st_add", 32'd1, 32'd2, 1'b0, 4'd2, 33'h0_0000_0003);
        run_op("st_sub", 32'd7, 32'd5, 1'b1, 4'd3, 33'h0_0000_0002);
        tick();
        tick();
`ifdef PIPE_ADDER_STATS_EN
        chk("st_res_count", res_count, 3);
        chk("st_carry_count", carry_count, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
